// File: rtl/pace_controller_if.sv
// rtl/pace_controller_if.sv - sense/enable inputs and pace/status outputs of the pacing controller
interface pace_controller_if #(
    parameter int PCNT_W = 16
);
    logic              sense_in;
    logic              enable;
    logic              pace_out;
    logic              sensed;
    logic              refractory;
    logic [PCNT_W-1:0] paced_cnt;

    modport master (
        output sense_in,
        output enable,
        input  pace_out,
        input  sensed,
        input  refractory,
        input  paced_cnt
    );

    modport slave (
        input  sense_in,
        input  enable,
        output pace_out,
        output sensed,
        output refractory,
        output paced_cnt
    );
endinterface

// File: rtl/pace_controller.sv
// rtl/pace_controller.sv - demand (VVI-style) pacer with refractory window, rate hysteresis and pace counter
module pace_controller #(
    parameter int CNT_W   = 32,
    parameter int LRI     = 24_000_000,
    parameter int HRI     = 30_000_000,
    parameter int PULSE_W = 12_000,
    parameter int REFRACT = 6_000_000,
    parameter int PCNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    pace_controller_if.slave    bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ALERT   = 2'd1;
    localparam logic [1:0] PACE    = 2'd2;
    localparam logic [1:0] REFR    = 2'd3;

    localparam logic [CNT_W-1:0]  LRI_C      = CNT_W'(LRI);
    localparam logic [CNT_W-1:0]  HRI_C      = CNT_W'(HRI);
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0]  REFR_LAST  = CNT_W'(REFRACT - 1);
    localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_SAT    = '1;
    localparam logic [PCNT_W-1:0] PCNT_MAX   = '1;
    localparam logic [PCNT_W-1:0] PONE       = PCNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  esc_q, esc_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]  interval_q, interval_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic              pace_out_q, pace_out_d;
    logic              sensed_q, sensed_d;
    logic              refractory_q, refractory_d;
    logic [PCNT_W-1:0] paced_cnt_q, paced_cnt_d;
    logic              sense_ev;

    always_comb begin
        // The edge detector runs in every state so a level held through refractory never fires later.
        sync1_d     = bus.sense_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        sense_ev    = sync2_q & ~prev_q;

        state_d     = state_q;
        esc_d       = (esc_q == CNT_SAT) ? esc_q : esc_q + ONE;
        phase_d     = phase_q + ONE;
        interval_d  = interval_q;
        sensed_d    = 1'b0;
        paced_cnt_d = paced_cnt_q;

        case (state_q)
            IDLE: begin
                esc_d   = '0;
                phase_d = '0;
                if (bus.enable) begin
                    state_d    = ALERT;
                    interval_d = LRI_C;
                end
            end
            ALERT: begin
                phase_d = '0;
                if (sense_ev) begin
                    sensed_d   = 1'b1;
                    esc_d      = '0;
                    interval_d = HRI_C;
                    state_d    = REFR;
                end else if (esc_q >= interval_q - ONE) begin
                    esc_d      = '0;
                    interval_d = LRI_C;
                    state_d    = PACE;
                    if (paced_cnt_q != PCNT_MAX) begin
                        paced_cnt_d = paced_cnt_q + PONE;
                    end
                end
            end
            PACE: begin
                if (phase_q == PULSE_LAST) begin
                    state_d = REFR;
                    phase_d = '0;
                end
            end
            REFR: begin
                if (phase_q == REFR_LAST) begin
                    state_d = ALERT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.enable) begin
            state_d     = IDLE;
            esc_d       = '0;
            phase_d     = '0;
            interval_d  = LRI_C;
            sensed_d    = 1'b0;
            paced_cnt_d = paced_cnt_q;
        end

        pace_out_d   = (state_d == PACE);
        refractory_d = (state_d == PACE) || (state_d == REFR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            esc_q        <= '0;
            phase_q      <= '0;
            interval_q   <= LRI_C;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            pace_out_q   <= 1'b0;
            sensed_q     <= 1'b0;
            refractory_q <= 1'b0;
            paced_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            esc_q        <= esc_d;
            phase_q      <= phase_d;
            interval_q   <= interval_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            pace_out_q   <= pace_out_d;
            sensed_q     <= sensed_d;
            refractory_q <= refractory_d;
            paced_cnt_q  <= paced_cnt_d;
        end
    end

    assign bus.pace_out   = pace_out_q;
    assign bus.sensed     = sensed_q;
    assign bus.refractory = refractory_q;
    assign bus.paced_cnt  = paced_cnt_q;
endmodule

// File: doc/pace_controller.md
# pace_controller

Parametrised demand (VVI-style) pacing controller, the next generation of the single-threshold pacer. It watches a synchronised intrinsic-beat sense input and tracks beat-to-beat time. It fires a pace pulse of programmable width when the escape interval expires. It adds a refractory (blanking) window, rate hysteresis after sensed beats, an enable control and a saturating pace counter. It sits between the sense front end and the pace output driver.

## Interface
- CNT_W, 32: width of the escape timer and phase counter.
- LRI, 24_000_000: lower-rate interval in clk cycles; the escape interval after a paced beat and after enable.
- HRI, 30_000_000: hysteresis interval in clk cycles; the escape interval after a sensed beat. Requires HRI >= LRI.
- PULSE_W, 12_000: pace pulse width in cycles, >= 1.
- REFRACT, 6_000_000: refractory window in cycles, >= 1. Requires LRI > PULSE_W + REFRACT.
- PCNT_W, 16: width of the pace counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sense_in  in  1  intrinsic heartbeat, asynchronous level.
- enable  in  1  synchronous pacing enable.
- pace_out  out  1  registered pace pulse.
- sensed  out  1  one-cycle pulse for each accepted intrinsic beat.
- refractory  out  1  high while in PACE or REFRACT.
- paced_cnt  out  PCNT_W  saturating count of pace pulses.

## Operation
- Sense path: 2-FF synchroniser, then a registered previous-value flop. A sense event is the rising edge of the synchronised level. Only 0->1 transitions count; a held-high level never re-triggers.
- esc_timer (CNT_W): resets to 0 on every pace start and on every accepted sense. Otherwise it increments and saturates at all-ones, with no wrap.
- phase_cnt (CNT_W): resets on entry to PACE or REFRACT and increments in those states.
- interval register: LRI after reset, enable-entry or pace; HRI after an accepted sense.
- States:
  - IDLE: enable low; all outputs low; timers held at 0. When enable is sampled high, go to ALERT with esc_timer=0 and interval=LRI.
  - ALERT: when a sense event occurs, pulse sensed, set esc_timer=0 and interval=HRI, and go to REFRACT. Else, when esc_timer >= interval-1, go to PACE with esc_timer=0 and interval=LRI.
  - PACE: pace_out high. When phase_cnt == PULSE_W-1, go to REFRACT with phase_cnt=0.
  - REFRACT: sense events are ignored but the edge detector keeps tracking. When phase_cnt == REFRACT-1, go to ALERT.
- Priority and boundary rules:
  - A sense event and a timeout in the same ALERT cycle: the sense wins and no pace is issued.
  - enable low in any state: go to IDLE on the next edge. An in-progress pulse is truncated and counts already made stand.
  - paced_cnt increments on each transition into PACE and saturates at 2^PCNT_W-1. Only rst clears it.
- Reset: rst asserted gives state IDLE, all timers 0, synchroniser flops 0, interval=LRI. pace_out, sensed, refractory and paced_cnt go to 0 immediately (asynchronous). Reset mid-pulse drops pace_out at once.

## Timing
- All outputs are registered and update on the edge that performs the state transition.
- Paced rhythm: the first pace_out rise is LRI edges after the ALERT-entry edge. Steady-state pace period is exactly LRI cycles. pace_out is high for exactly PULSE_W cycles.
- Sense latency: sense_in first sampled high at edge N (stable around that edge) gives sensed high for exactly the cycle after edge N+2, and refractory high from the same edge.
- After a sense accepted at edge S, with no further sense, the next pace_out rise is at edge S+HRI.
- refractory lasts PULSE_W+REFRACT cycles after a pace and REFRACT cycles after a sense.
- enable low sampled at edge E: pace_out and refractory are low after edge E.

## Test plan
- No sense, LRI=20, PULSE_W=3, REFRACT=5, enable sampled high at edge 0 -> pace_out rises at edges 20, 40, 60, each high for 3 cycles; paced_cnt reads 1, 2, 3.
- Same setup with HRI=30, sense_in rising sampled at edge 30 -> sensed high for one cycle after edge 32. There is no pace at edge 40; the next pace rises at edge 62.
- sense_in pulse sampled at edge 22, inside refractory, and a second sense_in held high from edge 24 through edge 50 -> no sensed pulse; paces stay at edges 20, 40, 60.
- Sense event detected on the same edge as the ALERT timeout (esc_timer=19) -> sensed fires, pace_out stays 0, paced_cnt is unchanged.
- rst asserted mid-pulse -> pace_out and paced_cnt are 0 before the next edge. enable dropped at pulse cycle 2 -> pace_out 0 after that edge; re-enabling gives the first pace LRI edges later.
- PCNT_W=4, run 20 paces -> paced_cnt reaches 15 and holds at 15.
